// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux_scan block: FSM state encodings, default
// geometry and a clog2 helper that never returns less than one bit.
package mux_scan_pkg;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam int DEF_N_CH   = 8;
    localparam int DEF_DATA_W = 1;
    localparam int DEF_DWELL  = 4;

    // Bits needed to count 0..value-1, with a floor of one bit so a
    // degenerate counter (value==1) still has a legal declaration.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < value) begin
                w = k + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_nw.sv
// Combinational N_CH:1 multiplexer of DATA_W-bit channels. An index that
// names no channel yields all zeros.
module mux_nw
    import mux_scan_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = $clog2(DEF_N_CH)
) (
    input  logic [N_CH*DATA_W-1:0] data,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      y
);

    logic [DATA_W-1:0] chan [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            assign chan[gi] = data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Explicit compare per channel so out-of-range indices fall through to zero.
    always_comb begin
        y = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                y = chan[k];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Registered N_CH:1 channel multiplexer with MANUAL (follow s) and SCAN
// (round-robin, DWELL cycles per channel) modes.
// Optional build macro MUX_SCAN_MASK_EN adds a per-channel enable mask that
// SCAN mode uses to skip disabled channels.
module mux_scan
    import mux_scan_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = $clog2(N_CH),
    parameter int DWELL  = DEF_DWELL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] i,
    input  logic [SEL_W-1:0]       s,
    input  logic                   mode,
    input  logic                   hold,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N_CH-1:0]        ch_en,
`endif
    output logic [DATA_W-1:0]      o,
    output logic [SEL_W-1:0]       ch,
    output logic                   valid,
    output logic                   wrap
);

    localparam int             CNT_W    = clog2_min1(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(N_CH - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [SEL_W-1:0]  ch_reg;
    logic [DATA_W-1:0] o_reg;
    logic              valid_reg;
    logic              wrap_reg;

    logic [SEL_W-1:0]  mux_sel;
    logic [DATA_W-1:0] mux_y;
    logic              s_in_range;
    logic [SEL_W-1:0]  next_ch;
    logic              next_wraps;
    logic              any_en;

    // In SCAN the mux reads the channel held during the previous cycle;
    // in MANUAL it reads the select input directly.
    assign mux_sel    = (state_reg == ST_SCAN) ? ch_reg : s;
    assign s_in_range = (int'(s) < N_CH);

    mux_nw #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .data (i),
        .sel  (mux_sel),
        .y    (mux_y)
    );

`ifdef MUX_SCAN_MASK_EN
    logic found;
    int   idx;

    // Search upward from ch+1 for the next enabled channel, wrapping once;
    // the advance wraps when the search passes index N_CH-1.
    always_comb begin
        next_ch    = ch_reg;
        next_wraps = 1'b0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = int'(ch_reg) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!found && ch_en[idx]) begin
                found      = 1'b1;
                next_ch    = SEL_W'(idx);
                next_wraps = (int'(ch_reg) + k >= N_CH);
            end
        end
    end

    assign any_en = |ch_en;
`else
    // Explicit compare against the last index so non-power-of-2 N_CH wraps.
    assign next_ch    = (ch_reg == CH_LAST) ? '0 : ch_reg + SEL_W'(1);
    assign next_wraps = (ch_reg == CH_LAST);
    assign any_en     = 1'b1;
`endif

    // Mode register, dwell counter, channel index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_MANUAL;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            o_reg     <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= mode ? ST_SCAN : ST_MANUAL;
            wrap_reg  <= 1'b0;
            if (state_reg == ST_MANUAL) begin
                cnt_reg <= '0;
                if (s_in_range) begin
                    ch_reg    <= s;
                    o_reg     <= mux_y;
                    valid_reg <= 1'b1;
                end else begin
                    o_reg     <= '0;
                    valid_reg <= 1'b0;
                end
            end else if (!any_en) begin
                // Nothing to scan: park on the current channel with no data.
                o_reg     <= '0;
                valid_reg <= 1'b0;
            end else begin
                o_reg     <= mux_y;
                valid_reg <= 1'b1;
                if (!hold) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg  <= '0;
                        ch_reg   <= next_ch;
                        wrap_reg <= next_wraps;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o     = o_reg;
    assign ch    = ch_reg;
    assign valid = valid_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan: an 8-channel instance (default geometry)
// plus a 6-channel instance for out-of-range select and mask behaviour.
module tb_mux_scan;

    localparam int NA  = 8;
    localparam int NB  = 6;
    localparam int DW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N_CH=8
    logic          rst, mode, hold;
    logic [NA-1:0] i;
    logic [2:0]    s;
    logic [0:0]    o;
    logic [2:0]    ch;
    logic          valid, wrap;

    // Instance B: N_CH=6
    logic          b_rst, b_mode, b_hold;
    logic [NB-1:0] b_i;
    logic [2:0]    b_s;
    logic [0:0]    b_o;
    logic [2:0]    b_ch;
    logic          b_valid, b_wrap;
`ifdef MUX_SCAN_MASK_EN
    logic [NA-1:0] a_ch_en;
    logic [NB-1:0] b_ch_en;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural reference for instance A
    int   m_state = 0;
    int   m_ch    = 0;
    int   m_cnt   = 0;
    logic m_o     = 1'b0;
    logic m_valid = 1'b0;
    logic m_wrap  = 1'b0;

    mux_scan #(.N_CH(NA), .DATA_W(1), .SEL_W(3), .DWELL(DW)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .i     (i),
        .s     (s),
        .mode  (mode),
        .hold  (hold),
`ifdef MUX_SCAN_MASK_EN
        .ch_en (a_ch_en),
`endif
        .o     (o),
        .ch    (ch),
        .valid (valid),
        .wrap  (wrap)
    );

    mux_scan #(.N_CH(NB), .DATA_W(1), .SEL_W(3), .DWELL(DW)) dut_b (
        .clk   (clk),
        .rst   (b_rst),
        .i     (b_i),
        .s     (b_s),
        .mode  (b_mode),
        .hold  (b_hold),
`ifdef MUX_SCAN_MASK_EN
        .ch_en (b_ch_en),
`endif
        .o     (b_o),
        .ch    (b_ch),
        .valid (b_valid),
        .wrap  (b_wrap)
    );

    // Reference: what instance A must show after the coming edge, given the
    // inputs now applied. Mode takes effect one cycle late; a scan visits
    // each channel for DW non-held cycles, in order, modulo NA.
    task automatic model_edge();
        if (rst) begin
            m_state = 0; m_ch = 0; m_cnt = 0;
            m_o = 1'b0; m_valid = 1'b0; m_wrap = 1'b0;
        end else if (m_state == 0) begin
            m_ch    = int'(s);
            m_o     = i[s];
            m_valid = 1'b1;
            m_cnt   = 0;
            m_wrap  = 1'b0;
            m_state = int'(mode);
        end else begin
            m_o     = i[m_ch];
            m_valid = 1'b1;
            m_wrap  = 1'b0;
            if (!hold) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == DW) begin
                    m_cnt  = 0;
                    m_wrap = (m_ch + 1 == NA);
                    m_ch   = (m_ch + 1) % NA;
                end
            end
            m_state = int'(mode);
        end
    endtask

    // One clock: update reference, take the edge, settle, log the transaction.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d a: ch=%0d o=%0d valid=%0d wrap=%0d | b: ch=%0d o=%0d valid=%0d wrap=%0d",
                 cyc, ch, o, valid, wrap, b_ch, b_o, b_valid, b_wrap);
    endtask

    task automatic test_reset();
        rst = 1'b1; b_rst = 1'b1;
        i = NA'($urandom); s = 3'($urandom); mode = 1'($urandom); hold = 1'($urandom);
        cycle();
        i = NA'($urandom); s = 3'($urandom); mode = 1'($urandom);
        cycle();
        checks++; if (o !== 1'b0)     begin failures++; $display("FAIL reset_o got=%0d exp=0", o); end
        checks++; if (ch !== 3'd0)    begin failures++; $display("FAIL reset_ch got=%0d exp=0", ch); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", valid); end
        checks++; if (wrap !== 1'b0)  begin failures++; $display("FAIL reset_wrap got=%0d exp=0", wrap); end
        checks++; if (b_valid !== 1'b0 || b_ch !== 3'd0) begin
            failures++; $display("FAIL reset_b got ch=%0d valid=%0d exp ch=0 valid=0", b_ch, b_valid);
        end
        rst = 1'b0; b_rst = 1'b0; mode = 1'b0; hold = 1'b0; s = 3'd0;
        cycle();
    endtask

    task automatic test_manual_walk();
        logic [NA-1:0] onehot;
        mode = 1'b0; hold = 1'b0;
        for (int k = 0; k < NA; k++) begin
            onehot = NA'(1) << k;
            i = onehot; s = 3'(k);
            cycle();
            checks++; if (o !== 1'b1 || ch !== 3'(k) || valid !== 1'b1) begin
                failures++;
                $display("FAIL manual_walk k=%0d got o=%0d ch=%0d valid=%0d exp o=1 ch=%0d valid=1", k, o, ch, valid, k);
            end
            i = ~onehot;
            cycle();
            checks++; if (o !== 1'b0 || wrap !== 1'b0) begin
                failures++; $display("FAIL manual_inv k=%0d got o=%0d wrap=%0d exp o=0 wrap=0", k, o, wrap);
            end
        end
    endtask

    // Start a scan from channel 0 with a fresh dwell: park manual on 0, then
    // raise mode; the edge that samples mode=1 still behaves as MANUAL.
    task automatic start_scan_from0();
        rst = 1'b1; cycle(); rst = 1'b0;
        hold = 1'b0; s = 3'd0; mode = 1'b0; cycle();
        mode = 1'b1; cycle();
    endtask

    task automatic test_scan_sweep();
        logic [NA-1:0] pat;
        int exp_ch, prev_ch, wraps;
        pat = NA'(8'h81);
        i = pat;
        start_scan_from0();
        wraps = 0;
        for (int n = 1; n <= 33; n++) begin
            cycle();
            exp_ch  = (n / DW) % NA;
            prev_ch = ((n - 1) / DW) % NA;
            if (wrap === 1'b1) wraps++;
            checks++; if (ch !== 3'(exp_ch) || o !== pat[prev_ch] || valid !== 1'b1) begin
                failures++;
                $display("FAIL scan_sweep n=%0d got ch=%0d o=%0d valid=%0d exp ch=%0d o=%0d valid=1",
                         n, ch, o, valid, exp_ch, pat[prev_ch]);
            end
            checks++; if (wrap !== ((n % (NA * DW)) == 0)) begin
                failures++; $display("FAIL scan_wrap n=%0d got=%0d exp=%0d", n, wrap, (n % (NA * DW)) == 0);
            end
        end
        checks++; if (wraps != 1) begin
            failures++; $display("FAIL scan_wrap_count got=%0d exp=1", wraps);
        end
    endtask

    task automatic test_hold();
        i = NA'($urandom);
        start_scan_from0();
        for (int n = 1; n <= 14; n++) cycle();
        checks++; if (ch !== 3'd3) begin failures++; $display("FAIL hold_setup got ch=%0d exp=3", ch); end
        hold = 1'b1;
        for (int n = 0; n < 5; n++) begin
            i = NA'($urandom);
            cycle();
            checks++; if (ch !== 3'd3 || wrap !== 1'b0) begin
                failures++; $display("FAIL hold_freeze n=%0d got ch=%0d wrap=%0d exp ch=3 wrap=0", n, ch, wrap);
            end
        end
        hold = 1'b0;
        cycle();
        checks++; if (ch !== 3'd3) begin failures++; $display("FAIL hold_release1 got ch=%0d exp=3", ch); end
        cycle();
        checks++; if (ch !== 3'd4) begin failures++; $display("FAIL hold_release2 got ch=%0d exp=4", ch); end
    endtask

    task automatic test_reset_mid_scan();
        // Continuing from ch=4 with a fresh dwell: four more edges reach ch=5.
        for (int n = 0; n < DW; n++) cycle();
        checks++; if (ch !== 3'd5) begin failures++; $display("FAIL midscan_setup got ch=%0d exp=5", ch); end
        rst = 1'b1; mode = 1'b1; s = 3'd0; i = '1;
        cycle();
        rst = 1'b0;
        checks++; if (ch !== 3'd0 || o !== 1'b0 || valid !== 1'b0) begin
            failures++; $display("FAIL midscan_reset got ch=%0d o=%0d valid=%0d exp 0/0/0", ch, o, valid);
        end
        cycle();
        checks++; if (ch !== 3'd0 || valid !== 1'b1) begin
            failures++; $display("FAIL midscan_resume got ch=%0d valid=%0d exp ch=0 valid=1", ch, valid);
        end
        for (int n = 1; n <= DW; n++) begin
            cycle();
            checks++; if (ch !== ((n == DW) ? 3'd1 : 3'd0)) begin
                failures++; $display("FAIL midscan_dwell n=%0d got ch=%0d exp=%0d", n, ch, (n == DW) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 300; n++) begin
            rst  = ($urandom_range(0, 99) < 2);
            mode = ($urandom_range(0, 9) < 7);
            hold = ($urandom_range(0, 9) < 2);
            s    = 3'($urandom);
            i    = NA'($urandom);
            cycle();
            bad = 0;
            checks++; if (o !== m_o)             bad++;
            checks++; if (ch !== 3'(m_ch))       bad++;
            checks++; if (valid !== m_valid)     bad++;
            checks++; if (wrap !== m_wrap)       bad++;
            if (bad != 0) begin
                failures += bad;
                $display("FAIL random n=%0d got o=%0d ch=%0d valid=%0d wrap=%0d exp o=%0d ch=%0d valid=%0d wrap=%0d",
                         n, o, ch, valid, wrap, m_o, m_ch, m_valid, m_wrap);
            end
        end
        rst = 1'b0; hold = 1'b0;
    endtask

    task automatic test_out_of_range();
        b_rst = 1'b1; cycle(); b_rst = 1'b0;
        b_mode = 1'b0; b_hold = 1'b0; b_i = '1;
        b_s = 3'd3; cycle();
        checks++; if (b_ch !== 3'd3 || b_o !== 1'b1 || b_valid !== 1'b1) begin
            failures++; $display("FAIL oor_in got ch=%0d o=%0d valid=%0d exp 3/1/1", b_ch, b_o, b_valid);
        end
        b_s = 3'd7; cycle();
        checks++; if (b_ch !== 3'd3 || b_o !== 1'b0 || b_valid !== 1'b0) begin
            failures++; $display("FAIL oor_s7 got ch=%0d o=%0d valid=%0d exp 3/0/0", b_ch, b_o, b_valid);
        end
        b_s = 3'd6; cycle();
        checks++; if (b_ch !== 3'd3 || b_o !== 1'b0 || b_valid !== 1'b0) begin
            failures++; $display("FAIL oor_s6 got ch=%0d o=%0d valid=%0d exp 3/0/0", b_ch, b_o, b_valid);
        end
        b_s = 3'd5; cycle();
        checks++; if (b_ch !== 3'd5 || b_valid !== 1'b1) begin
            failures++; $display("FAIL oor_s5 got ch=%0d valid=%0d exp 5/1", b_ch, b_valid);
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        int exp_ch;
        b_ch_en = 6'b100101;
        b_i = '1; b_hold = 1'b0; b_s = 3'd0; b_mode = 1'b0; cycle();
        b_mode = 1'b1; cycle();
        for (int n = 1; n <= 12; n++) begin
            cycle();
            exp_ch = (n < 4) ? 0 : (n < 8) ? 2 : (n < 12) ? 5 : 0;
            checks++; if (b_ch !== 3'(exp_ch) || b_wrap !== (n == 12)) begin
                failures++;
                $display("FAIL mask_seq n=%0d got ch=%0d wrap=%0d exp ch=%0d wrap=%0d", n, b_ch, b_wrap, exp_ch, n == 12);
            end
        end
        b_ch_en = '0;
        cycle(); cycle();
        checks++; if (b_ch !== 3'd0 || b_valid !== 1'b0 || b_o !== 1'b0) begin
            failures++; $display("FAIL mask_none got ch=%0d valid=%0d o=%0d exp 0/0/0", b_ch, b_valid, b_o);
        end
        b_mode = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; hold = 1'b0; i = '0; s = '0;
        b_rst = 1'b1; b_mode = 1'b0; b_hold = 1'b0; b_i = '0; b_s = '0;
`ifdef MUX_SCAN_MASK_EN
        a_ch_en = '1;
        b_ch_en = '1;
`endif
        test_reset();
        test_manual_walk();
        test_scan_sweep();
        test_hold();
        test_reset_mid_scan();
        test_random();
        test_out_of_range();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N:1 multiplexer of W-bit channels. Successor to the fixed 8:1 combinational mux.
- Two modes:
  - MANUAL: the channel follows the select input.
  - SCAN: channels are visited round-robin, with a programmable dwell time per channel.
- Feeds the board display/LED path, which cycles through inputs without software help.

Parameters:
- N_CH, 8, number of input channels (>=2).
- DATA_W, 1, width of each channel in bits.
- SEL_W, $clog2(N_CH) (3 at defaults), select/channel index width.
- DWELL, 4, clock cycles spent on each channel in SCAN mode (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i  input  N_CH*DATA_W  packed channel data; channel k = i[k*DATA_W +: DATA_W].
- s  input  SEL_W  manual channel select.
- mode  input  1  0 = MANUAL, 1 = SCAN.
- hold  input  1  SCAN only: freeze the dwell counter and the channel.
- o  output  DATA_W  registered selected data.
- ch  output  SEL_W  channel currently selected (registered).
- valid  output  1  o holds legal channel data.
- wrap  output  1  one-cycle pulse when the scan advances from N_CH-1 to 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=MANUAL, o=0, ch=0, valid=0, wrap=0, dwell cnt=0.
  - rst overrides all other inputs.
- State register:
  - state <= mode each edge, so the mode takes effect one cycle after sampling.
  - Two states: MANUAL(0), SCAN(1).
- MANUAL, s < N_CH: ch<=s; o<=i[s]; valid<=1. Latency is one cycle.
- MANUAL, s >= N_CH: ch holds its previous value; o<=0; valid<=0.
- MANUAL, always: cnt held at 0 and wrap=0.
- SCAN, every edge: o<=i[ch]. o reflects the channel held in ch during the previous cycle. valid<=1.
- SCAN, advance:
  - If !hold and cnt==DWELL-1: cnt<=0; ch<=(ch==N_CH-1)?0:ch+1; wrap<=(ch==N_CH-1).
  - Else if !hold: cnt<=cnt+1; wrap<=0.
  - If hold: cnt and ch unchanged; wrap<=0.
- MANUAL->SCAN: the scan starts from the current ch with cnt=0, so the first channel gets a full DWELL.
- SCAN->MANUAL: cnt is cleared and ch follows s from the next edge.
- DWELL=1: the channel advances every non-held cycle.
- Arithmetic:
  - cnt width is $clog2(DWELL), min 1.
  - The ch increment compares explicitly against N_CH-1 rather than relying on natural overflow, so non-power-of-2 N_CH wraps correctly.

Optional Feature:
- Macro MUX_SCAN_MASK_EN.
- When defined:
  - Adds input ch_en [N_CH]; SCAN advances to the next enabled channel in ascending order, wrapping.
  - wrap pulses when the advance passes index N_CH-1.
  - If ch_en is all zero: ch holds, o<=0, valid<=0.
  - If the current ch is disabled at a dwell boundary, it is skipped normally.
  - MANUAL ignores ch_en.
- When undefined: the port is absent and all channels are scanned.

Decomposition:
- Shared package/header mux_scan_pkg holds:
  - state encodings ST_MANUAL=1'b0, ST_SCAN=1'b1;
  - default N_CH/DATA_W/DWELL;
  - a clog2 helper function.
- One sub-module, mux_nw: combinational N_CH:1 mux of DATA_W bits, indexed by SEL_W, returning 0 for out-of-range index. Instantiated once; the FSM, counter and output registers stay in mux_scan.

Test Plan:
- Defaults for all tests: N_CH=8, DATA_W=1, DWELL=4.
- Reset: rst=1 for 2 edges with arbitrary i/s/mode -> o=0, ch=0, valid=0, wrap=0; state MANUAL.
- Manual walk: mode=0; for k=0..7 set i=1<<k, s=k. After one edge -> o=1, ch=k, valid=1. Then s=k with i=~(1<<k) -> o=0.
- Scan sweep: mode=1, ch=0, i=8'b10000001.
  - ch steps 0,1..7,0 every 4 cycles; o=1 while sampling ch 0 and 7.
  - wrap=1 for exactly one cycle on the 7->0 advance; full period 32 cycles.
- Hold: in SCAN, assert hold at cnt=2 on ch=3 for 5 cycles -> ch stays 3, wrap=0. After release, ch=3 for 2 more cycles, then 4.
- Reset mid-scan: rst for one edge at ch=5, mode kept 1 -> ch=0, o=0, valid=0. One edge later state=SCAN, and ch=0 dwells 4 cycles.
- Out-of-range (N_CH=6): mode=0, s=3 then s=7 -> ch stays 3, o=0, valid=0. With MUX_SCAN_MASK_EN and ch_en=6'b100101 in SCAN -> ch sequence 0,2,5,0 with wrap on 5->0.
